raster_sequencer: RTL and testbench

RASTER_SEQUENCER -- requirements
Module: raster_sequencer

---
 rtl/raster_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_raster_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_sequencer.sv
// Frame sequencer for a bank of voxel shaders: rasterizes every voxel, shades every
// palette entry, then copies one pixel per shader into the framebuffer.
module raster_sequencer #(
    parameter int COORD_BITS    = 8,
    parameter int PALETTE_BITS  = 8,
    parameter int PIXEL_BITS    = 8,
    parameter int INDEX_BITS    = 32,
    parameter int NUM_SHADERS   = 4,
    parameter int VOX_ADDR_BITS = 12,
    parameter int TIMEOUT       = 255
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [VOX_ADDR_BITS:0]                voxel_count,
    input  logic [PALETTE_BITS:0]                 palette_count,
    output logic                                  vox_rd,
    output logic [VOX_ADDR_BITS-1:0]              vox_addr,
    input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  vox_rdata,
    output logic                                  pal_rd,
    output logic [PALETTE_BITS-1:0]               pal_addr,
    input  logic [PIXEL_BITS-1:0]                 pal_rdata,
    output logic                                  shader_clear,
    output logic                                  do_rasterize,
    output logic                                  do_shade,
    output logic [COORD_BITS-1:0]                 voxel_x,
    output logic [COORD_BITS-1:0]                 voxel_y,
    output logic [COORD_BITS-1:0]                 voxel_z,
    output logic [PALETTE_BITS-1:0]               voxel_id,
    output logic [PIXEL_BITS-1:0]                 palette_entry,
    output logic [INDEX_BITS-1:0]                 pixel_index,
    input  logic [PIXEL_BITS-1:0]                 pixel,
    input  logic [NUM_SHADERS-1:0]                rasterizing_done,
    input  logic [NUM_SHADERS-1:0]                shading_done,
    input  logic [NUM_SHADERS-1:0]                shader_error,
    output logic                                  fb_we,
    output logic [INDEX_BITS-1:0]                 fb_addr,
    output logic [PIXEL_BITS-1:0]                 fb_wdata,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  timeout,
    output logic [15:0]                           error_count
);

    localparam int WAIT_BITS = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_BITS-1:0]     WAIT_ONE  = 1;
    localparam logic [WAIT_BITS-1:0]     WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);
    localparam logic [VOX_ADDR_BITS:0]   VOX_ONE   = 1;
    localparam logic [PALETTE_BITS:0]    PAL_ONE   = 1;
    localparam logic [INDEX_BITS-1:0]    IDX_ONE   = 1;
    localparam logic [INDEX_BITS-1:0]    IDX_LAST  = INDEX_BITS'(NUM_SHADERS - 1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, FETCH_VOX, LATCH_VOX, RASTER, RASTER_WAIT,
        FETCH_PAL, LATCH_PAL, SHADE, SHADE_WAIT, READOUT, DONE
    } state_t;

    state_t                   state, state_next;
    logic [VOX_ADDR_BITS-1:0] v;
    logic [PALETTE_BITS-1:0]  p;
    logic [INDEX_BITS-1:0]    r;
    logic [NUM_SHADERS-1:0]   flags, flags_next;
    logic                     err_seen, err_next;
    logic [WAIT_BITS-1:0]     wait_cnt;
    logic                     all_done, expired, wait_exit;
    logic                     vox_more, pal_more, last_read;

    // Wait-phase bookkeeping: the current cycle's responses count toward the exit decision.
    always_comb begin
        flags_next = flags | ((state == RASTER_WAIT) ? (rasterizing_done | shader_error)
                                                     : shading_done);
        err_next   = err_seen | (|shader_error);
        all_done   = &flags_next;
        expired    = (wait_cnt == WAIT_LAST);
        wait_exit  = all_done | expired;
        vox_more   = (({1'b0, v} + VOX_ONE) < voxel_count);
        pal_more   = (({1'b0, p} + PAL_ONE) < palette_count);
        last_read  = (r == IDX_LAST);
    end

    always_comb begin
        state_next   = state;
        vox_rd       = (state == FETCH_VOX);
        vox_addr     = v;
        pal_rd       = (state == FETCH_PAL);
        pal_addr     = p;
        shader_clear = reset | (state == CLEAR);
        do_rasterize = (state == RASTER);
        do_shade     = (state == SHADE);
        fb_we        = (state == READOUT);
        pixel_index  = (state == READOUT) ? r : '0;
        fb_addr      = (state == READOUT) ? r : '0;
        fb_wdata     = pixel;
        busy         = (state != IDLE);
        frame_done   = (state == DONE);

        case (state)
            IDLE:        if (start) state_next = CLEAR;
            CLEAR: begin
                if (voxel_count != '0)        state_next = FETCH_VOX;
                else if (palette_count != '0) state_next = FETCH_PAL;
                else                          state_next = READOUT;
            end
            FETCH_VOX:   state_next = LATCH_VOX;
            LATCH_VOX:   state_next = RASTER;
            RASTER:      state_next = RASTER_WAIT;
            RASTER_WAIT: begin
                if (wait_exit) begin
                    if (vox_more)                 state_next = FETCH_VOX;
                    else if (palette_count != '0) state_next = FETCH_PAL;
                    else                          state_next = READOUT;
                end
            end
            FETCH_PAL:   state_next = LATCH_PAL;
            LATCH_PAL:   state_next = SHADE;
            SHADE:       state_next = SHADE_WAIT;
            SHADE_WAIT:  if (wait_exit) state_next = pal_more ? FETCH_PAL : READOUT;
            READOUT:     if (last_read) state_next = DONE;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Only voxel-phase errors count toward error_count; timeouts from either phase are sticky.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            v             <= '0;
            p             <= '0;
            r             <= '0;
            flags         <= '0;
            err_seen      <= 1'b0;
            wait_cnt      <= '0;
            timeout       <= 1'b0;
            error_count   <= '0;
            voxel_x       <= '0;
            voxel_y       <= '0;
            voxel_z       <= '0;
            voxel_id      <= '0;
            palette_entry <= '0;
        end else begin
            state <= state_next;
            r     <= (state == READOUT && !last_read) ? r + IDX_ONE : '0;
            case (state)
                CLEAR: begin
                    timeout     <= 1'b0;
                    error_count <= '0;
                    v           <= '0;
                    p           <= '0;
                end
                LATCH_VOX: {voxel_x, voxel_y, voxel_z, voxel_id} <= vox_rdata;
                LATCH_PAL: begin
                    voxel_id      <= p;
                    palette_entry <= pal_rdata;
                end
                RASTER, SHADE: begin
                    flags    <= '0;
                    err_seen <= 1'b0;
                    wait_cnt <= '0;
                end
                RASTER_WAIT, SHADE_WAIT: begin
                    flags    <= flags_next;
                    err_seen <= err_next;
                    wait_cnt <= wait_cnt + WAIT_ONE;
                    if (wait_exit) begin
                        if (!all_done) timeout <= 1'b1;
                        if (state == RASTER_WAIT) begin
                            if (err_next && error_count != 16'hFFFF)
                                error_count <= error_count + 16'd1;
                            if (vox_more) v <= v + 1'b1;
                        end else if (pal_more) begin
                            p <= p + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_sequencer.sv
// Self-checking bench for raster_sequencer: behavioural shaders and memories, a
// table of whole-frame vectors, and hand-written reset sequences.
module tb_raster_sequencer;

    localparam int NS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [12:0] voxel_count = '0;
    logic [8:0]  palette_count = '0;
    logic        vox_rd;
    logic [11:0] vox_addr;
    logic [31:0] vox_rdata = '0;
    logic        pal_rd;
    logic [7:0]  pal_addr;
    logic [7:0]  pal_rdata = '0;
    logic        shader_clear, do_rasterize, do_shade;
    logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id, palette_entry;
    logic [31:0] pixel_index;
    logic [7:0]  pixel;
    logic [NS-1:0] rasterizing_done = '0;
    logic [NS-1:0] shading_done = '0;
    logic [NS-1:0] shader_error = '0;
    logic        fb_we;
    logic [31:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        busy, frame_done, timeout;
    logic [15:0] error_count;

    raster_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .voxel_count(voxel_count), .palette_count(palette_count),
        .vox_rd(vox_rd), .vox_addr(vox_addr), .vox_rdata(vox_rdata),
        .pal_rd(pal_rd), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
        .shader_clear(shader_clear), .do_rasterize(do_rasterize), .do_shade(do_shade),
        .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
        .palette_entry(palette_entry), .pixel_index(pixel_index), .pixel(pixel),
        .rasterizing_done(rasterizing_done), .shading_done(shading_done),
        .shader_error(shader_error),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .busy(busy), .frame_done(frame_done), .timeout(timeout), .error_count(error_count)
    );

    always #5 clock = ~clock;

    // Shared pixel bus: each shader's pixel is a fixed function of its index.
    assign pixel = 8'h5A ^ pixel_index[7:0];

    logic [31:0]   vox_mem [8];
    logic [7:0]    pal_mem [8];
    logic [NS-1:0] err_mask = '0;
    logic [NS-1:0] silent = '0;

    int rcnt [NS];
    int scnt [NS];
    int n_rast, n_shade, n_fb, n_done, n_clear, n_consec, bad_data, bad_stab;
    int rast_idx, shade_idx, fb_idx;
    bit holding, prev_pulse;
    logic [31:0] held;

    // Environment: memories, shaders answering 5 cycles after each command, and event monitors.
    always @(negedge clock) begin
        rasterizing_done = '0;
        shading_done     = '0;
        shader_error     = '0;
        if (vox_rd) vox_rdata = vox_mem[vox_addr[2:0]];
        if (pal_rd) pal_rdata = pal_mem[pal_addr[2:0]];
        if (shader_clear) begin
            rast_idx = 0; shade_idx = 0; fb_idx = 0; holding = 0;
            n_clear++;
        end
        if (do_rasterize) begin
            n_rast++;
            if ({voxel_x, voxel_y, voxel_z, voxel_id} != vox_mem[rast_idx[2:0]]) begin
                bad_data++;
                $display("[TB] note: voxel %0d broadcast %h", rast_idx, {voxel_x, voxel_y, voxel_z, voxel_id});
            end
            held = {voxel_x, voxel_y, voxel_z, voxel_id};
            holding = 1;
            rast_idx++;
        end else if (holding) begin
            if (vox_rd || pal_rd || fb_we || !busy) holding = 0;
            else if ({voxel_x, voxel_y, voxel_z, voxel_id} != held) bad_stab++;
        end
        if (do_shade) begin
            n_shade++;
            if (voxel_id != shade_idx[7:0] || palette_entry != pal_mem[shade_idx[2:0]]) begin
                bad_data++;
                $display("[TB] note: palette %0d broadcast id=%0d entry=%h", shade_idx, voxel_id, palette_entry);
            end
            shade_idx++;
        end
        if (fb_we) begin
            n_fb++;
            if (fb_addr != 32'(fb_idx) || pixel_index != 32'(fb_idx) || fb_wdata != (8'h5A ^ fb_idx[7:0])) begin
                bad_data++;
                $display("[TB] note: fb write %0d addr=%0d data=%h", fb_idx, fb_addr, fb_wdata);
            end
            fb_idx++;
        end
        if (frame_done) n_done++;
        if ((do_rasterize || do_shade || shader_clear) && prev_pulse) n_consec++;
        prev_pulse = do_rasterize || do_shade || shader_clear;
        for (int i = 0; i < NS; i++) begin
            if (do_rasterize) rcnt[i] = 5;
            else if (rcnt[i] > 0) begin
                rcnt[i]--;
                if (rcnt[i] == 0 && !silent[i]) begin
                    if (err_mask[i] && rast_idx == 1) shader_error[i] = 1'b1;
                    else rasterizing_done[i] = 1'b1;
                end
            end
            if (do_shade) scnt[i] = 5;
            else if (scnt[i] > 0) begin
                scnt[i]--;
                if (scnt[i] == 0 && !silent[i]) shading_done[i] = 1'b1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int            vc;
        int            pc;
        logic [NS-1:0] em;
        logic [NS-1:0] sm;
        bit            mid;
        int            e_rast;
        int            e_shade;
        int            e_fb;
        logic          e_to;
        int            e_err;
        int            e_cyc;
    } vec_t;

    vec_t vecs [7];

    // One whole frame: start pulse, bounded wait for frame_done, then a quiet period.
    task automatic apply_stimulus(input vec_t t, input int idx);
        int b_rast, b_shade, b_fb, b_done, b_clear, b_consec, b_data, b_stab;
        int cyc, mid_wait;
        bit seen, pulsed;
        string tag;
        tag = $sformatf("v%0d", idx);
        tick();
        voxel_count   = 13'(t.vc);
        palette_count = 9'(t.pc);
        err_mask      = t.em;
        silent        = t.sm;
        b_rast = n_rast; b_shade = n_shade; b_fb = n_fb; b_done = n_done;
        b_clear = n_clear; b_consec = n_consec; b_data = bad_data; b_stab = bad_stab;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; mid_wait = 0; seen = 0; pulsed = 0;
        while (!seen && cyc < 5000) begin
            tick();
            cyc++;
            start = 1'b0;
            if (n_done != b_done) seen = 1;
            else if (t.mid && !pulsed && n_rast != b_rast) begin
                mid_wait++;
                if (mid_wait == 3) begin
                    start = 1'b1;
                    pulsed = 1;
                end
            end
        end
        start = 1'b0;
        check_output({tag, " frame_cycles"}, cyc, t.e_cyc);
        repeat (20) tick();
        check_output({tag, " do_rasterize"}, n_rast - b_rast, t.e_rast);
        check_output({tag, " do_shade"}, n_shade - b_shade, t.e_shade);
        check_output({tag, " fb_writes"}, n_fb - b_fb, t.e_fb);
        check_output({tag, " frame_done"}, n_done - b_done, 1);
        check_output({tag, " shader_clear"}, n_clear - b_clear, 1);
        check_output({tag, " timeout"}, timeout, t.e_to);
        check_output({tag, " error_count"}, error_count, t.e_err);
        check_output({tag, " consecutive_pulses"}, n_consec - b_consec, 0);
        check_output({tag, " broadcast_data"}, bad_data - b_data, 0);
        check_output({tag, " voxel_hold"}, bad_stab - b_stab, 0);
        check_output({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        int cyc;
        int b;
        vec_t post;
        for (int k = 0; k < 8; k++) begin
            vox_mem[k] = {8'(8'h10 + k), 8'(8'h21 + 3 * k), 8'(8'h37 + 5 * k), 8'(8'h4C + k)};
            pal_mem[k] = 8'(8'hC3 + 7 * k);
        end
        //            vc pc  em    sm    mid  rast shade fb  to    err cyc
        vecs[0] = '{2, 2, 4'h0, 4'h0, 1'b0, 2, 2, 4, 1'b0, 0, 37};
        vecs[1] = '{0, 0, 4'h0, 4'h0, 1'b0, 0, 0, 4, 1'b0, 0, 5};
        vecs[2] = '{2, 2, 4'h4, 4'h0, 1'b0, 2, 2, 4, 1'b0, 1, 37};
        vecs[3] = '{2, 1, 4'h0, 4'h8, 1'b0, 2, 1, 4, 1'b1, 0, 779};
        vecs[4] = '{3, 2, 4'h0, 4'h0, 1'b1, 3, 2, 4, 1'b0, 0, 45};
        vecs[5] = '{1, 0, 4'h0, 4'h0, 1'b0, 1, 0, 4, 1'b0, 0, 13};
        vecs[6] = '{0, 3, 4'h0, 4'h0, 1'b0, 0, 3, 4, 1'b0, 0, 29};

        tick();
        tick();
        check_output("rst busy", busy, 0);
        check_output("rst shader_clear", shader_clear, 1);
        check_output("rst frame_done", frame_done, 0);
        check_output("rst timeout", timeout, 0);
        check_output("rst error_count", error_count, 0);
        check_output("rst vox_rd", vox_rd, 0);
        check_output("rst fb_we", fb_we, 0);
        check_output("rst voxel_x", voxel_x, 0);
        check_output("rst pixel_index", pixel_index, 0);
        reset = 1'b0;
        tick();
        check_output("idle shader_clear", shader_clear, 0);
        check_output("idle busy", busy, 0);

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

        voxel_count = 13'd1;
        palette_count = 9'd1;
        err_mask = '0;
        silent = '0;
        b = n_shade;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (n_shade == b && cyc < 200) begin
            tick();
            cyc++;
        end
        check_output("rsw reached_shade", n_shade - b, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_output("rsw busy", busy, 0);
        check_output("rsw do_shade", do_shade, 0);
        check_output("rsw do_rasterize", do_rasterize, 0);
        check_output("rsw frame_done", frame_done, 0);
        check_output("rsw fb_we", fb_we, 0);
        check_output("rsw pal_rd", pal_rd, 0);
        check_output("rsw shader_clear", shader_clear, 1);
        check_output("rsw voxel_id", voxel_id, 0);
        check_output("rsw palette_entry", palette_entry, 0);
        check_output("rsw error_count", error_count, 0);
        reset = 1'b0;
        tick();
        check_output("rsw idle busy", busy, 0);
        check_output("rsw idle shader_clear", shader_clear, 0);
        repeat (10) tick();
        post = vecs[0];
        apply_stimulus(post, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
